// File: rtl/pm8_seq_ctrl.sv
// pm8_seq_ctrl: sequential 8x8 unsigned multiplier built around one shared
// 4x4 nibble multiplier. The four partial products are produced one per
// cycle and shift-accumulated into a 16-bit product.
//
// Optional feature macro: PM8_SEQ_ZERO_SKIP_EN
//   defined   -> a zero operand bypasses the four MUL steps (latency 1)
//   undefined -> every operation runs all four MUL steps (latency 4)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds data stable while valid is high and ready is
// low. in_ready depends only on the FSM state, never on in_valid. out_valid
// does not depend on out_ready, and c stays stable while out_valid is high.
//
// The FSM state is the internal signal 'state' (state_t), and 'step' is the
// partial-product index. Both can be bound to directly from checkers.
module pm8_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      c,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [1:0]  step;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc;

  logic        accept;
  logic        finish;
  logic        deliver;

  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_sh;
  logic [15:0] acc_sum;

`ifdef PM8_SEQ_ZERO_SKIP_EN
  logic        zero_q;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;
  assign accept   = in_valid && in_ready;

  // Select the nibble pair for the current step and align its partial product.
  // step[0] picks the high nibble of a, step[1] the high nibble of b.
  always_comb begin
    nib_a = step[0] ? a_q[7:4] : a_q[3:0];
    nib_b = step[1] ? b_q[7:4] : b_q[3:0];
    pp    = {4'd0, nib_a} * {4'd0, nib_b};
    case (step)
      2'd0:    pp_sh = {8'd0, pp};
      2'd1:    pp_sh = {4'd0, pp, 4'd0};
      2'd2:    pp_sh = {4'd0, pp, 4'd0};
      default: pp_sh = {pp, 8'd0};
    endcase
    acc_sum = acc + pp_sh;
  end

  // Next-state logic and the one-cycle strobes that drive the datapath.
  always_comb begin
    state_d = state;
    finish  = 1'b0;
    deliver = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = MUL;
        end
      end
      MUL: begin
`ifdef PM8_SEQ_ZERO_SKIP_EN
        if (zero_q || (step == 2'd3)) begin
          state_d = DONE;
          finish  = 1'b1;
        end
`else
        if (step == 2'd3) begin
          state_d = DONE;
          finish  = 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          deliver = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset wins over everything, including an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Datapath: operand latch, accumulator/step counter, result and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      acc       <= 16'd0;
      step      <= 2'd0;
      c         <= 16'd0;
      out_valid <= 1'b0;
      op_count  <= '0;
`ifdef PM8_SEQ_ZERO_SKIP_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        acc    <= 16'd0;
        step   <= 2'd0;
`ifdef PM8_SEQ_ZERO_SKIP_EN
        zero_q <= (a == 8'd0) || (b == 8'd0);
`endif
      end
      if (state == MUL) begin
        acc  <= acc_sum;
        step <= step + 2'd1;
      end
      if (finish) begin
`ifdef PM8_SEQ_ZERO_SKIP_EN
        c <= zero_q ? 16'd0 : acc_sum;
`else
        c <= acc_sum;
`endif
        out_valid <= 1'b1;
      end
      if (deliver) begin
        out_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pm8_seq_ctrl.sv
// tb_pm8_seq_ctrl: directed vector bench for pm8_seq_ctrl (CNT_W = 4 so the
// counter wrap can be reached quickly).
module tb_pm8_seq_ctrl;

  localparam int CNT_W = 4;

`ifdef PM8_SEQ_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 4;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      c;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  pm8_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .busy      (busy),
    .op_count  (op_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  int               n_vec;
  int               n_bad;
  logic [15:0]      exp_q[$];
  logic [CNT_W-1:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one operation starting in IDLE. keep_valid leaves in_valid high after
  // the accept edge so the next call's operands are already presented.
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb,
                       input logic [15:0] vc, input int exp_lat,
                       input int hold, input bit keep_valid);
    int          lat;
    logic [15:0] exp_c;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    exp_q.push_back(vc);
    tick();                                   // accept edge
    if (!keep_valid) begin
      in_valid = 1'b0;
      a        = 8'($urandom_range(0, 255));  // must not disturb the result
      b        = 8'($urandom_range(0, 255));
    end
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    exp_c = exp_q.pop_front();
    check("product", 32'(c), 32'(exp_c));
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_c", 32'(c), 32'(exp_c));
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    tick();                                   // delivery edge
    exp_cnt = exp_cnt + CNT_W'(1);
    check("out_valid_clr", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("op_count", 32'(op_count), 32'(exp_cnt));
    check("c_kept", 32'(c), 32'(exp_c));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] vc;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    exp_cnt   = '0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = 8'd0;
    b         = 8'd0;
    out_ready = 1'b1;

    vecs[0] = '{8'h0F, 8'h0F, 16'h00E1, 4, 0};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 4, 0};
    vecs[2] = '{8'hA5, 8'h3C, 16'h26AC, 4, 0};
    vecs[3] = '{8'h12, 8'h34, 16'h03A8, 4, 3};
    vecs[4] = '{8'h00, 8'h7B, 16'h0000, ZERO_LAT, 0};
    vecs[5] = '{8'h80, 8'h02, 16'h0100, 4, 0};
    vecs[6] = '{8'hFF, 8'h01, 16'h00FF, 4, 1};
    vecs[7] = '{8'h10, 8'h10, 16'h0100, 4, 0};
    vecs[8] = '{8'h7B, 8'h00, 16'h0000, ZERO_LAT, 0};

    // Reset state
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);

    // Table-driven products
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].lat, vecs[i].hold, 1'b0);
      tick();
    end

    // Reset in the middle of MUL (before step 2 executes)
    in_valid = 1'b1;
    a        = 8'hA5;
    b        = 8'h3C;
    tick();                                   // accept
    in_valid = 1'b0;
    tick();                                   // step 0
    tick();                                   // step 1
    check("mid_busy", 32'(busy), 32'd1);
    do_reset();
    exp_cnt = '0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_c", 32'(c), 32'd0);
    check("mid_rst_op_count", 32'(op_count), 32'd0);
    do_op(8'hA5, 8'h3C, 16'h26AC, 4, 0, 1'b0);

    // 17 back-to-back ops with in_valid held high: counter wraps to 1
    do_reset();
    exp_cnt = '0;
    for (int i = 0; i < 17; i++) begin
      do_op(8'h0F, 8'h0F, 16'h00E1, 4, 0, (i != 16));
    end
    check("wrap_op_count", 32'(op_count), 32'd1);
    tick();
    tick();
    check("idle_stays", 32'(in_ready), 32'd1);
    check("idle_count_stable", 32'(op_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
